lm_sm_sequencer: RTL and testbench

- Sits in the ID/RR stage directly downstream of the instruction decoder.
- Consumes the decoder's LM/SM flags and the Imm9 register mask, and expands one multiple load/store instruction into a sequence of single-register memory micro-ops, one per set mask bit.
- Each micro-op carries a register index and a 16-bit memory address.
- Holds fetch/decode stalled until the last micro-op issues.

---
 rtl/lm_sm_sequencer.sv | 117 +++++++++++
 tb/tb_lm_sm_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lm_sm_sequencer.sv
// Expands one LM/SM instruction into single-register memory micro-ops, one per
// set bit of the register mask, lowest register first, holding fetch until done.
module lm_sm_sequencer #(
    parameter int ADDR_W = 16,
    parameter int NREGS  = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    input  logic              dec_lm,
    input  logic              dec_sm,
    input  logic [15:0]       instr,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              hold,
    input  logic              flush,
    output logic              busy,
    output logic              stall_fetch,
    output logic              uop_valid,
    output logic              uop_load,
    output logic [REG_AW-1:0] uop_reg,
    output logic [ADDR_W-1:0] uop_addr,
    output logic              uop_last,
    output logic              dbg_state
);

    localparam int OFF_W = REG_AW + 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [NREGS-1:0]   mask_q;
    logic [OFF_W-1:0]   offset_q;
    logic [ADDR_W-1:0]  base_q;
    logic               type_q;

    logic               start_ok;
    logic               run;
    logic               advance;
    logic               one_left;
    logic [REG_AW-1:0]  low_idx;
    logic               instr_unused;

    assign instr_unused = ^instr[15:NREGS];

    // Handshake: a micro-op is consumed by downstream on any cycle with
    // uop_valid=1, hold=0 and flush=0; while hold=1 the same micro-op stays put.
    assign start_ok = dec_valid & (dec_lm ^ dec_sm) & (|instr[NREGS-1:0]) & ~flush & ~hold;
    assign run      = (state_q == RUN);
    assign advance  = run & ~hold & ~flush;
    assign one_left = (|mask_q) & ~(|(mask_q & (mask_q - NREGS'(1))));

    always_comb begin
        low_idx = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (mask_q[i]) low_idx = REG_AW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        stall_fetch = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d     = RUN;
                    stall_fetch = 1'b1;
                end
            end
            RUN: begin
                // Fetch is released as the final micro-op leaves.
                stall_fetch = ~(one_left & ~hold);
                if (advance && one_left) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d     = IDLE;
            stall_fetch = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q   <= '0;
            offset_q <= '0;
            base_q   <= '0;
            type_q   <= 1'b0;
        end else if (flush) begin
            mask_q   <= '0;
            offset_q <= '0;
        end else if (state_q == IDLE && start_ok) begin
            mask_q   <= instr[NREGS-1:0];
            base_q   <= base_addr;
            type_q   <= dec_lm;
            offset_q <= '0;
        end else if (advance) begin
            mask_q   <= mask_q & (mask_q - NREGS'(1));
            offset_q <= offset_q + OFF_W'(1);
        end
    end

    // Outputs are gated to zero outside RUN so IDLE never shows a stale address.
    assign busy      = run;
    assign uop_valid = run;
    assign uop_load  = run & type_q;
    assign uop_reg   = run ? low_idx : '0;
    assign uop_addr  = run ? (base_q + ADDR_W'(offset_q)) : '0;
    assign uop_last  = run & one_left;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Randomised bench for lm_sm_sequencer: a driver pushes the expected micro-op
// list per instruction, a negedge monitor pops and compares what the DUT issues.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dec_valid = 1'b0;
    logic        dec_lm = 1'b0;
    logic        dec_sm = 1'b0;
    logic [15:0] instr = '0;
    logic [15:0] base_addr = '0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic        busy, stall_fetch, uop_valid, uop_load, uop_last, dbg_state;
    logic [2:0]  uop_reg;
    logic [15:0] uop_addr;

    // {load, reg, addr, last}
    logic [20:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int cnt_stall = 0;
    int cnt_busy = 0;
    int cnt_hold = 0;

    lm_sm_sequencer dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_lm(dec_lm),
        .dec_sm(dec_sm), .instr(instr), .base_addr(base_addr), .hold(hold),
        .flush(flush), .busy(busy), .stall_fetch(stall_fetch),
        .uop_valid(uop_valid), .uop_load(uop_load), .uop_reg(uop_reg),
        .uop_addr(uop_addr), .uop_last(uop_last), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: compare every presented micro-op against the head of the queue.
    always @(negedge clk) begin
        if (stall_fetch) cnt_stall++;
        if (busy) cnt_busy++;
        if (busy && hold) cnt_hold++;
        if (uop_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL uop_unexpected reg=%0d addr=%h", uop_reg, uop_addr);
            end else begin
                if ({uop_load, uop_reg, uop_addr, uop_last} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL uop got load=%0d reg=%0d addr=%h last=%0d want load=%0d reg=%0d addr=%h last=%0d",
                             uop_load, uop_reg, uop_addr, uop_last,
                             exp_q[0][20], exp_q[0][19:17], exp_q[0][16:1], exp_q[0][0]);
                end
                if (flush) exp_q.delete();
                else if (!hold) void'(exp_q.pop_front());
            end
        end
    end

    task automatic push_expected(input bit lm, input logic [7:0] mask, input logic [15:0] base);
        int n;
        int k;
        n = $countones(mask);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                exp_q.push_back({lm, 3'(i), base + 16'(k), (k == n - 1)});
                k++;
            end
        end
    endtask

    task automatic drive_instr(input bit lm, input bit sm, input logic [7:0] mask, input logic [15:0] base);
        dec_valid = 1'b1;
        dec_lm    = lm;
        dec_sm    = sm;
        instr     = {8'($urandom), mask};
        base_addr = base;
    endtask

    // Called at posedge+1; returns at posedge+1 with the sequencer idle.
    // hold_mode: 0 none, 1 random, 2 held for the first two RUN cycles.
    task automatic run_seq(input bit lm, input bit sm, input logic [7:0] mask,
                           input logic [15:0] base, input int hold_mode);
        bit ok;
        int n;
        int cyc;
        ok = (lm ^ sm) && (mask != 0);
        n  = ok ? $countones(mask) : 0;
        cnt_stall = 0; cnt_busy = 0; cnt_hold = 0;
        if (ok) push_expected(lm, mask, base);
        drive_instr(lm, sm, mask, base);
        @(posedge clk); #1;
        cyc = 0;
        while (busy && cyc < 100) begin
            // Decoder fields are don't-care while the sequence runs.
            dec_valid = 1'($urandom);
            dec_lm    = 1'($urandom);
            dec_sm    = 1'($urandom);
            instr     = 16'($urandom);
            base_addr = 16'($urandom);
            hold = (hold_mode == 1) ? ($urandom_range(0, 3) == 0) :
                   (hold_mode == 2) ? (cyc < 2) : 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        hold = 1'b0;
        dec_valid = 1'b0;
        check("seq_timeout", 32'(cyc >= 100), 32'd0);
        check("seq_drained", exp_q.size(), 32'd0);
        check("stall_cycles", cnt_stall, ok ? n + cnt_hold : 0);
        check("busy_cycles", cnt_busy, ok ? n + cnt_hold : 0);
        if (hold_mode == 2 && ok) check("hold_cycles", cnt_hold, 32'd2);
    endtask

    // An instruction that must not start: no stall, no micro-op.
    task automatic no_start(input bit lm, input bit sm, input logic [7:0] mask, input bit h, input bit f);
        drive_instr(lm, sm, mask, 16'($urandom));
        hold = h; flush = f;
        #1;
        check("nostart_stall", stall_fetch, 32'd0);
        @(posedge clk); #1;
        dec_valid = 1'b0; hold = 1'b0; flush = 1'b0;
        check("nostart_busy", busy, 32'd0);
        check("nostart_uop", uop_valid, 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {busy, stall_fetch, uop_valid, uop_load, uop_reg, uop_addr, uop_last, dbg_state}, 32'd0);
    endtask

    initial begin
        #2;
        check_all_zero("reset_outputs");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle_outputs");

        run_seq(1'b1, 1'b0, 8'hA5, 16'h0100, 0);
        run_seq(1'b0, 1'b1, 8'h0F, 16'hFFFE, 0);
        run_seq(1'b0, 1'b1, 8'h80, 16'h1234, 0);
        run_seq(1'b1, 1'b0, 8'h06, 16'h2000, 2);

        no_start(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        no_start(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        no_start(1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
        no_start(1'b1, 1'b0, 8'h3C, 1'b1, 1'b0);
        no_start(1'b0, 1'b1, 8'h3C, 1'b0, 1'b1);

        // Flush while the second micro-op of a full mask is presented.
        push_expected(1'b1, 8'hFF, 16'h4000);
        drive_instr(1'b1, 1'b0, 8'hFF, 16'h4000);
        @(posedge clk); #1;
        dec_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        #1;
        check("flush_stall", stall_fetch, 32'd0);
        check("flush_uop_reg", uop_reg, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", busy, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("flush_drained", exp_q.size(), 32'd0);

        // Asynchronous reset during the third micro-op of a full mask.
        push_expected(1'b1, 8'hFF, 16'h5000);
        drive_instr(1'b1, 1'b0, 8'hFF, 16'h5000);
        @(posedge clk); #1;
        dec_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_reg", uop_reg, 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        exp_q.delete();
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        run_seq(1'b1, 1'b0, 8'h9C, 16'h6000, 0);

        for (int t = 0; t < 24; t++) begin
            bit lm;
            lm = 1'($urandom);
            run_seq(lm, ~lm, 8'($urandom_range(1, 255)), 16'($urandom), 1);
        end

        repeat (3) @(posedge clk);
        #1;
        check("final_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
